// File: rtl/ofm_buffer.sv
// Output feature-map buffer: NUM_CH banks of DEPTH words with overwrite/accumulate
// writes, a whole-buffer clear sweep and a channel-major ready/valid drain.
module ofm_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int NUM_CH = 4,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] wrData,
  input  logic              acc,
  input  logic              clr,
  input  logic              done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              drain_done,
  output logic              wr_drop
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W + 1)'(DEPTH);
  localparam logic [CH_W:0]     NCH_W     = (CH_W + 1)'(NUM_CH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CH - 1);

  logic [1:0]        state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_drop_q;
  logic              wr_ok;
  logic [DATA_W-1:0] rd_word [NUM_CH];

  assign wr_ok = wr && (state_q == S_IDLE)
              && ({1'b0, address} < DEPTH_W) && ({1'b0, wr_ch} < NCH_W);

  // One bank per channel so a clear sweep can zero the same address everywhere at once.
  // Reads are asynchronous so an accumulate sees the previous result at the same edge.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_bank
      logic [DATA_W-1:0] bank [DEPTH];
      logic              hit;

      assign hit = wr_ok && (wr_ch == CH_W'(gi));

      always_ff @(posedge clk) begin
        if (!rst) begin
          if (state_q == S_CLEAR) begin
            bank[addr_q] <= '0;
          end else if (hit) begin
            bank[address] <= acc ? (bank[address] + wrData) : wrData;
          end
        end
      end

      assign rd_word[gi] = bank[addr_q];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        if (clr) begin
          state_d = S_CLEAR;
          ch_d    = '0;
          addr_d  = '0;
        end else if (done) begin
          state_d = S_DRAIN;
          ch_d    = '0;
          addr_d  = '0;
        end
      end
      S_CLEAR: begin
        if (addr_q == LAST_ADDR) begin
          state_d = S_IDLE;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (addr_q == LAST_ADDR) begin
            addr_d = '0;
            if (ch_q == LAST_CH) begin
              state_d = S_FIN;
              ch_d    = '0;
            end else begin
              ch_d = ch_q + 1'b1;
            end
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        ch_d    = '0;
        addr_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ch_q      <= '0;
      addr_q    <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      addr_q    <= addr_d;
      wr_drop_q <= wr && !wr_ok;
    end
  end

  assign out_valid  = (state_q == S_DRAIN);
  assign out_ch     = out_valid ? ch_q : '0;
  assign out_addr   = out_valid ? addr_q : '0;
  assign out_data   = out_valid ? rd_word[ch_q] : '0;
  assign busy       = (state_q != S_IDLE);
  assign drain_done = (state_q == S_FIN);
  assign wr_drop    = wr_drop_q;

endmodule
